// File: rtl/reg_file_p_pkg.sv
// Shared CPU register-file defaults.
// CPU_WIDTH : default bits per register at the CPU top
// CPU_NREG  : default number of architectural registers
package reg_file_p_pkg;

  localparam int unsigned CPU_WIDTH = 4;
  localparam int unsigned CPU_NREG  = 4;

endpackage

// File: rtl/reg_file_p_reg.sv
// One register word with load enable, asynchronous active-low clear and a
// sticky "written since reset" flag.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low clear of word and flag
//   en      - load strobe
//   d       - load data
//   q       - stored word
//   written - set on the first load after reset
module reg_en_w
  import reg_file_p_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             written
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      written <= 1'b0;
    end else if (en) begin
      q       <= d;
      written <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_p.sv
// Parametrised CPU register file: DEPTH words of WIDTH bits, two
// combinational read ports and one synchronous write port, with optional
// write-to-read bypass and optional hardwired-zero R0.
// Ports:
//   clk, rst_n        - clock and asynchronous active-low clear
//   sel_a, sel_b      - read indices
//   write_en, sel_w   - write strobe and index
//   data_in           - write data
//   out_a, out_b      - read data (combinational)
//   valid_a, valid_b  - selected register written since reset
//   q_all             - all stored words, word i at [i*WIDTH +: WIDTH]
module reg_file_p
  import reg_file_p_pkg::*;
#(
  parameter int unsigned WIDTH   = CPU_WIDTH,
  parameter int unsigned DEPTH   = CPU_NREG,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AW-1:0]          sel_a,
  input  logic [AW-1:0]          sel_b,
  input  logic                   write_en,
  input  logic [AW-1:0]          sel_w,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       out_a,
  output logic [WIDTH-1:0]       out_b,
  output logic                   valid_a,
  output logic                   valid_b,
  output logic [DEPTH*WIDTH-1:0] q_all
);

  // Packed so that word i lands at [i*WIDTH +: WIDTH] of q_all directly.
  logic [DEPTH-1:0][WIDTH-1:0] word;
  logic [DEPTH-1:0]            flag;
  logic [DEPTH-1:0]            we;
  logic                        wr_hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (ZERO_R0 && i == 0) begin : g_zero
      assign we[i]   = 1'b0;
      assign word[i] = '0;
      assign flag[i] = 1'b1;
    end else begin : g_store
      assign we[i] = write_en & (sel_w == AW'(i));
      reg_en_w #(.WIDTH(WIDTH)) u_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (we[i]),
        .d       (data_in),
        .q       (word[i]),
        .written (flag[i])
      );
    end
  end

  // we[] is already empty for out-of-range and zero-R0 targets, so a set bit
  // means the write is legal and may be forwarded. Gating with rst_n keeps
  // read outputs cleared while reset is held.
  assign wr_hit = (|we) & rst_n;
  assign q_all  = word;

  always_comb begin
    out_a   = '0;
    out_b   = '0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    // Loop-based mux: unmatched (out-of-range) selects fall through to 0.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_a == AW'(i)) begin
        out_a   = word[i];
        valid_a = flag[i];
      end
      if (sel_b == AW'(i)) begin
        out_b   = word[i];
        valid_b = flag[i];
      end
    end
    if (BYPASS && wr_hit && (sel_w == sel_a)) begin
      out_a   = data_in;
      valid_a = 1'b1;
    end
    if (BYPASS && wr_hit && (sel_w == sel_b)) begin
      out_b   = data_in;
      valid_b = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_p.sv
module tb_reg_file_p;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Group A: WIDTH=4, DEPTH=4, instances with BYPASS=1 (a1) and BYPASS=0 (a0)
  logic [1:0]  a_sa, a_sb, a_sw;
  logic        a_we;
  logic [3:0]  a_din;
  logic [3:0]  a1_oa, a1_ob, a0_oa, a0_ob;
  logic        a1_va, a1_vb, a0_va, a0_vb;
  logic [15:0] a1_q, a0_q;

  // Group B: WIDTH=8, DEPTH=6, ZERO_R0=1, BYPASS=1 (b1) and BYPASS=0 (b0)
  logic [2:0]  b_sa, b_sb, b_sw;
  logic        b_we;
  logic [7:0]  b_din;
  logic [7:0]  b1_oa, b1_ob, b0_oa, b0_ob;
  logic        b1_va, b1_vb, b0_va, b0_vb;
  logic [47:0] b1_q, b0_q;

  reg_file_p #(.WIDTH(4), .DEPTH(4), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_a1 (
    .clk(clk), .rst_n(rst_n), .sel_a(a_sa), .sel_b(a_sb), .write_en(a_we),
    .sel_w(a_sw), .data_in(a_din), .out_a(a1_oa), .out_b(a1_ob),
    .valid_a(a1_va), .valid_b(a1_vb), .q_all(a1_q));

  reg_file_p #(.WIDTH(4), .DEPTH(4), .BYPASS(1'b0), .ZERO_R0(1'b0)) u_a0 (
    .clk(clk), .rst_n(rst_n), .sel_a(a_sa), .sel_b(a_sb), .write_en(a_we),
    .sel_w(a_sw), .data_in(a_din), .out_a(a0_oa), .out_b(a0_ob),
    .valid_a(a0_va), .valid_b(a0_vb), .q_all(a0_q));

  reg_file_p #(.WIDTH(8), .DEPTH(6), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .sel_a(b_sa), .sel_b(b_sb), .write_en(b_we),
    .sel_w(b_sw), .data_in(b_din), .out_a(b1_oa), .out_b(b1_ob),
    .valid_a(b1_va), .valid_b(b1_vb), .q_all(b1_q));

  reg_file_p #(.WIDTH(8), .DEPTH(6), .BYPASS(1'b0), .ZERO_R0(1'b1)) u_b0 (
    .clk(clk), .rst_n(rst_n), .sel_a(b_sa), .sel_b(b_sb), .write_en(b_we),
    .sel_w(b_sw), .data_in(b_din), .out_a(b0_oa), .out_b(b0_ob),
    .valid_a(b0_va), .valid_b(b0_vb), .q_all(b0_q));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag,
                       input logic [3:0] ea1, input logic [3:0] eb1, input logic eva1, input logic evb1,
                       input logic [3:0] ea0, input logic [3:0] eb0, input logic eva0, input logic evb0,
                       input logic [15:0] eq);
    check({tag, ".a1_out_a"}, 64'(a1_oa), 64'(ea1));
    check({tag, ".a1_out_b"}, 64'(a1_ob), 64'(eb1));
    check({tag, ".a1_valid_a"}, 64'(a1_va), 64'(eva1));
    check({tag, ".a1_valid_b"}, 64'(a1_vb), 64'(evb1));
    check({tag, ".a1_q_all"}, 64'(a1_q), 64'(eq));
    check({tag, ".a0_out_a"}, 64'(a0_oa), 64'(ea0));
    check({tag, ".a0_out_b"}, 64'(a0_ob), 64'(eb0));
    check({tag, ".a0_valid_a"}, 64'(a0_va), 64'(eva0));
    check({tag, ".a0_valid_b"}, 64'(a0_vb), 64'(evb0));
    check({tag, ".a0_q_all"}, 64'(a0_q), 64'(eq));
  endtask

  task automatic chk_b(input string tag,
                       input logic [7:0] ea1, input logic [7:0] eb1, input logic eva1, input logic evb1,
                       input logic [7:0] ea0, input logic [7:0] eb0, input logic eva0, input logic evb0,
                       input logic [47:0] eq);
    check({tag, ".b1_out_a"}, 64'(b1_oa), 64'(ea1));
    check({tag, ".b1_out_b"}, 64'(b1_ob), 64'(eb1));
    check({tag, ".b1_valid_a"}, 64'(b1_va), 64'(eva1));
    check({tag, ".b1_valid_b"}, 64'(b1_vb), 64'(evb1));
    check({tag, ".b1_q_all"}, 64'(b1_q), 64'(eq));
    check({tag, ".b0_out_a"}, 64'(b0_oa), 64'(ea0));
    check({tag, ".b0_out_b"}, 64'(b0_ob), 64'(eb0));
    check({tag, ".b0_valid_a"}, 64'(b0_va), 64'(eva0));
    check({tag, ".b0_valid_b"}, 64'(b0_vb), 64'(evb0));
    check({tag, ".b0_q_all"}, 64'(b0_q), 64'(eq));
  endtask

  task automatic set_a(input logic we, input logic [1:0] sw, input logic [3:0] din,
                       input logic [1:0] sa, input logic [1:0] sb);
    a_we = we; a_sw = sw; a_din = din; a_sa = sa; a_sb = sb;
  endtask

  task automatic set_b(input logic we, input logic [2:0] sw, input logic [7:0] din,
                       input logic [2:0] sa, input logic [2:0] sb);
    b_we = we; b_sw = sw; b_din = din; b_sa = sa; b_sb = sb;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(1'b0, 2'd0, 4'h0, 2'd0, 2'd1);
    set_b(1'b0, 3'd0, 8'h00, 3'd0, 3'd1);
    #3;
    chk_a("rst_init", 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 16'h0000);
    chk_b("rst_init", 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 48'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Write R2=A then R3=5 on consecutive edges
    set_a(1'b1, 2'd2, 4'hA, 2'd0, 2'd0);
    step();
    set_a(1'b1, 2'd3, 4'h5, 2'd2, 2'd3);
    step();
    set_a(1'b0, 2'd0, 4'h0, 2'd2, 2'd3);
    #1;
    chk_a("wr23", 4'hA, 4'h5, 1, 1, 4'hA, 4'h5, 1, 1, 16'h5A00);
    set_a(1'b0, 2'd0, 4'h0, 2'd0, 2'd1);
    #1;
    chk_a("r01", 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 16'h5A00);

    // Bypass: R1 holds 3, same-cycle write of C to R1 read on both ports
    set_a(1'b1, 2'd1, 4'h3, 2'd0, 2'd1);
    step();
    set_a(1'b1, 2'd1, 4'hC, 2'd1, 2'd1);
    #1;
    chk_a("byp_pre", 4'hC, 4'hC, 1, 1, 4'h3, 4'h3, 1, 1, 16'h5A30);
    step();
    set_a(1'b0, 2'd1, 4'hC, 2'd1, 2'd1);
    #1;
    chk_a("byp_post", 4'hC, 4'hC, 1, 1, 4'hC, 4'hC, 1, 1, 16'h5AC0);

    // write_en low with a live-looking write to R2 over 3 edges
    set_a(1'b0, 2'd2, 4'hF, 2'd2, 2'd1);
    step(); step(); step();
    chk_a("no_we", 4'hA, 4'hC, 1, 1, 4'hA, 4'hC, 1, 1, 16'h5AC0);

    // Mid-cycle reset clears everything without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("rst_mid", 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 16'h0000);
    // Writes while in reset are ignored and not forwarded
    set_a(1'b1, 2'd2, 4'h7, 2'd2, 2'd2);
    #1;
    chk_a("rst_byp", 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 16'h0000);
    step();
    set_a(1'b0, 2'd0, 4'h0, 2'd2, 2'd2);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_a("rst_rel", 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 16'h0000);
    step();

    // Group B: write R4=44
    set_b(1'b1, 3'd4, 8'h44, 3'd4, 3'd5);
    #1;
    chk_b("b_w4_pre", 8'h44, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 48'h0);
    step();
    set_b(1'b0, 3'd0, 8'h00, 3'd4, 3'd5);
    #1;
    chk_b("b_w4", 8'h44, 8'h00, 1, 0, 8'h44, 8'h00, 1, 0, 48'h0044_0000_0000);

    // Out-of-range writes and reads
    set_b(1'b1, 3'd7, 8'hFF, 3'd7, 3'd6);
    #1;
    chk_b("b_oor_pre", 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 48'h0044_0000_0000);
    step();
    set_b(1'b1, 3'd6, 8'hFF, 3'd6, 3'd7);
    step();
    set_b(1'b0, 3'd0, 8'h00, 3'd6, 3'd7);
    #1;
    chk_b("b_oor", 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 48'h0044_0000_0000);

    // Full 8-bit data to R3
    set_b(1'b1, 3'd3, 8'hA5, 3'd3, 3'd4);
    #1;
    chk_b("b_w3_pre", 8'hA5, 8'h44, 1, 1, 8'h00, 8'h44, 0, 1, 48'h0044_0000_0000);
    step();
    set_b(1'b0, 3'd0, 8'h00, 3'd3, 3'd4);
    #1;
    chk_b("b_w3", 8'hA5, 8'h44, 1, 1, 8'hA5, 8'h44, 1, 1, 48'h0044_A500_0000);

    // Hardwired-zero R0: write dropped, never forwarded, always valid
    set_b(1'b1, 3'd0, 8'h55, 3'd0, 3'd0);
    #1;
    chk_b("b_r0_pre", 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 1, 1, 48'h0044_A500_0000);
    step();
    set_b(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    #1;
    chk_b("b_r0_post", 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 1, 1, 48'h0044_A500_0000);

    // Reset asserted in the same cycle as a write to R4
    set_b(1'b1, 3'd4, 8'h99, 3'd4, 3'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_b("b_rst_wr", 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 48'h0);
    step();
    set_b(1'b0, 3'd0, 8'h00, 3'd4, 3'd3);
    #2;
    rst_n = 1'b1;
    #1;
    chk_b("b_rst_rel", 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 48'h0);
    step();
    chk_b("b_rst_hold", 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 48'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
